// File: rtl/seg_scan.sv
// Four-digit multiplexed hex display scanner with a one-entry frame buffer.
// A new frame is captured on load and committed to the display at the end of the scan.
module seg_scan #(
  parameter int unsigned DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  blank,
  input  logic [3:0]  dpi,
  output logic        busy,
  output logic        ack,
  output logic        frame,
  output logic [3:0]  hex,
  output logic [3:0]  an,
  output logic        dp
);

  localparam logic [15:0] LP_LAST = 16'(DIV - 1);

  logic [15:0] r_cnt;
  logic [1:0]  r_sel;
  logic        r_busy;
  logic        r_ack;
  logic [15:0] r_pd_data;
  logic [3:0]  r_pd_blank;
  logic [3:0]  r_pd_dp;
  logic [15:0] r_sh_data;
  logic [3:0]  r_sh_blank;
  logic [3:0]  r_sh_dp;

  logic        w_tick;
  logic        w_frame;
  logic        w_dark;

  assign w_tick  = (r_cnt == LP_LAST);
  assign w_frame = w_tick && (r_sel == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_sel      <= '0;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_pd_data  <= '0;
      r_pd_blank <= '0;
      r_pd_dp    <= '0;
      r_sh_data  <= '0;
      r_sh_blank <= '1;
      r_sh_dp    <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 16'd1;
      if (w_tick) begin
        r_sel <= r_sel + 2'd1;
      end
      r_ack <= 1'b0;
      // Commit has priority; a load arriving in the commit cycle sees busy=1 and is dropped.
      if (w_frame && r_busy) begin
        r_sh_data  <= r_pd_data;
        r_sh_blank <= r_pd_blank;
        r_sh_dp    <= r_pd_dp;
        r_busy     <= 1'b0;
        r_ack      <= 1'b1;
      end else if (load && !r_busy) begin
        r_pd_data  <= data;
        r_pd_blank <= blank;
        r_pd_dp    <= dpi;
        r_busy     <= 1'b1;
      end
    end
  end

  // First cycle of every slot is forced dark to avoid ghosting between digits.
  assign w_dark = (r_cnt == '0) || r_sh_blank[r_sel];

  always_comb begin
    hex = 4'(r_sh_data >> {r_sel, 2'b00});
    an  = w_dark ? 4'b1111 : ~(4'b0001 << r_sel);
    dp  = r_sh_dp[r_sel] & ~w_dark;
  end

  assign busy  = r_busy;
  assign ack   = r_ack;
  assign frame = w_frame;

endmodule
